// File: rtl/rom_lookup_arbiter.sv
// Two-requester round-robin front end for a shared synchronous key ROM: linear scan from
// address 0 with a zero sentinel. Define LAST_HIT_CACHE_EN to add a last-hit shortcut cache.
module rom_lookup_arbiter #(
  parameter int KEY_W       = 16,
  parameter int ADDR_W      = 4,
  parameter int ROM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [KEY_W-1:0]  key0,
  input  logic              req1,
  input  logic [KEY_W-1:0]  key1,
  output logic              done0,
  output logic              done1,
  output logic              found,
  output logic [ADDR_W-1:0] match_addr,
  output logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [KEY_W-1:0]  rom_q
);

  localparam int               CNT_W     = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [KEY_W-1:0]  KEY_ZERO  = {KEY_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [KEY_W-1:0]  key_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_r;
  logic              fast_r;
  logic              fast_found_r;
  logic [ADDR_W-1:0] fast_addr_r;

  logic              pick_s;
  logic [KEY_W-1:0]  pick_key_s;
  logic              hit_s;
  logic              cache_hit_s;
  logic [ADDR_W-1:0] cache_addr_s;

`ifdef LAST_HIT_CACHE_EN
  logic              cache_valid_r;
  logic [KEY_W-1:0]  cache_key_r;
  logic [ADDR_W-1:0] cache_addr_r;
`endif

  // Round-robin pick: the requester not granted last wins a tie
  always_comb begin
    pick_s = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    pick_key_s = pick_s ? key1 : key0;
    hit_s      = (rom_q != KEY_ZERO) && (rom_q == key_r);
  end

  // Cache lookup for the key being granted
  always_comb begin
`ifdef LAST_HIT_CACHE_EN
    cache_hit_s  = cache_valid_r && (pick_key_s == cache_key_r);
    cache_addr_s = cache_addr_r;
`else
    cache_hit_s  = 1'b0;
    cache_addr_s = ADDR_ZERO;
`endif
  end

`ifdef LAST_HIT_CACHE_EN
  // Last-hit cache, overwritten by every ROM hit regardless of requester
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_r <= 1'b0;
      cache_key_r   <= KEY_ZERO;
      cache_addr_r  <= ADDR_ZERO;
    end else if (state_r == CHECK && hit_s) begin
      cache_valid_r <= 1'b1;
      cache_key_r   <= key_r;
      cache_addr_r  <= rom_addr;
    end else begin
      cache_valid_r <= cache_valid_r;
    end
  end
`endif

  // Arbitration and scan state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      key_r        <= KEY_ZERO;
      cnt_r        <= CNT_ZERO;
      last_r       <= 1'b1;
      fast_r       <= 1'b0;
      fast_found_r <= 1'b0;
      fast_addr_r  <= ADDR_ZERO;
      rom_addr     <= ADDR_ZERO;
      done0        <= 1'b0;
      done1        <= 1'b0;
      found        <= 1'b0;
      match_addr   <= ADDR_ZERO;
      grant        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req0 || req1) begin
            key_r  <= pick_key_s;
            grant  <= pick_s;
            last_r <= pick_s;
            busy   <= 1'b1;
            cnt_r  <= CNT_ZERO;
            // Zero key and cache hits skip the ROM; the result is issued from DONE next cycle
            if (pick_key_s == KEY_ZERO) begin
              rom_addr     <= ADDR_ZERO;
              fast_r       <= 1'b1;
              fast_found_r <= 1'b0;
              fast_addr_r  <= ADDR_ZERO;
              state_r      <= DONE;
            end else if (cache_hit_s) begin
              fast_r       <= 1'b1;
              fast_found_r <= 1'b1;
              fast_addr_r  <= cache_addr_s;
              state_r      <= DONE;
            end else begin
              rom_addr <= ADDR_ZERO;
              state_r  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= CHECK;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        CHECK: begin
          if (hit_s) begin
            found      <= 1'b1;
            match_addr <= rom_addr;
            done0      <= ~grant;
            done1      <= grant;
            state_r    <= DONE;
          end else if (rom_q == KEY_ZERO || rom_addr == ADDR_LAST) begin
            found      <= 1'b0;
            match_addr <= ADDR_ZERO;
            done0      <= ~grant;
            done1      <= grant;
            state_r    <= DONE;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            cnt_r    <= CNT_ZERO;
            state_r  <= WAIT;
          end
        end
        DONE: begin
          if (fast_r) begin
            fast_r     <= 1'b0;
            found      <= fast_found_r;
            match_addr <= fast_addr_r;
            done0      <= ~grant;
            done1      <= grant;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Scoreboard bench for rom_lookup_arbiter with a behavioural 2-cycle ROM; expectations for the
// cache scenario follow whether LAST_HIT_CACHE_EN is defined.
module tb_rom_lookup_arbiter;

  localparam int KEY_W   = 16;
  localparam int ADDR_W  = 4;
  localparam int ROM_LAT = 2;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [KEY_W-1:0]  key0, key1, rom_q;
  logic              done0, done1, found, grant, busy;
  logic [ADDR_W-1:0] match_addr, rom_addr;

  logic [KEY_W-1:0]  mem  [DEPTH];
  logic [KEY_W-1:0]  pipe [ROM_LAT];

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    logic              idx;
    logic              fnd;
    logic [ADDR_W-1:0] addr;
    int                lat;
  } exp_t;
  exp_t sb[$];

  rom_lookup_arbiter #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .ROM_LATENCY(ROM_LAT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .key0(key0), .req1(req1), .key1(key1),
    .done0(done0), .done1(done1), .found(found), .match_addr(match_addr),
    .grant(grant), .busy(busy), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  // ROM model: data appears ROM_LAT edges after the address
  always @(posedge clk) begin
    pipe[0] <= mem[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_q = pipe[ROM_LAT-1];

  task automatic load_rom_a();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hABCD;
    mem[4] = 16'h0000;
    for (int i = 5; i < DEPTH; i++) mem[i] = 16'h0F00 + 16'(i);
    mem[6] = 16'h5555;
  endtask

  task automatic push_exp(input logic idx, input logic fnd, input logic [ADDR_W-1:0] addr,
                          input int lat);
    exp_t n;
    n.idx = idx; n.fnd = fnd; n.addr = addr; n.lat = lat;
    sb.push_back(n);
  endtask

  task automatic start_req(input logic idx, input logic [KEY_W-1:0] key);
    @(negedge clk);
    if (idx) begin req1 = 1'b1; key1 = key; end
    else begin req0 = 1'b1; key0 = key; end
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok, output int lat,
                           output logic [6:0] res, output logic bsy);
    ok = 1'b0; lat = 0; res = 7'd0; bsy = 1'b0;
    while (!ok && lat < budget) begin
      @(posedge clk); #1; lat++;
      if (done0 || done1) begin
        ok  = 1'b1;
        res = {done0, done1, found, match_addr};
        bsy = busy;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; key0 = 16'h0000; key1 = 16'h0000;
    load_rom_a();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({done0, done1, found, match_addr, grant, busy, rom_addr} !== 13'd0) begin
      failures++;
      $display("FAIL reset_state: got %b, expected all zero",
               {done0, done1, found, match_addr, grant, busy, rom_addr});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hit_and_miss();
    logic        idx_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] key_t [3] = '{16'hABCD, 16'h5555, 16'h0000};
    logic        fnd_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0]  adr_t [3] = '{4'd3, 4'd0, 4'd0};
    int          lat_t [3] = '{12, 15, 1};
    logic [3:0]  ra_t  [3] = '{4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 3; i++) begin
      exp_t e; bit ok; int lat; logic [6:0] res; logic bsy; logic [3:0] ra;
      push_exp(idx_t[i], fnd_t[i], adr_t[i], lat_t[i]);
      start_req(idx_t[i], key_t[i]);
      wait_done(100, ok, lat, res, bsy);
      ra = rom_addr;
      e = sb.pop_front();
      if (e.idx) req1 = 1'b0; else req0 = 1'b0;
      tests_run++;
      if (!ok || res !== {~e.idx, e.idx, e.fnd, e.addr}) begin
        failures++;
        $display("FAIL lookup%0d_result: got d0/d1/found/addr %b, expected %b (done seen %0d)",
                 i, res, {~e.idx, e.idx, e.fnd, e.addr}, ok);
      end
      tests_run++;
      if (lat != e.lat) begin
        failures++;
        $display("FAIL lookup%0d_latency: got %0d cycles, expected %0d", i, lat, e.lat);
      end
      tests_run++;
      if (bsy !== 1'b1 || ra !== ra_t[i]) begin
        failures++;
        $display("FAIL lookup%0d_busy_romaddr: got busy=%b rom_addr=%0d, expected 1/%0d",
                 i, bsy, ra, ra_t[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({done0, done1, busy} !== 3'b000) begin
        failures++;
        $display("FAIL lookup%0d_after_done: got done0/done1/busy %b, expected 000", i,
                 {done0, done1, busy});
      end
    end
  endtask

  task automatic test_full_miss();
    exp_t e; bit ok; int lat; logic [6:0] res; logic bsy; logic [3:0] ra;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 + 16'(i + 1);
    push_exp(1'b0, 1'b0, 4'd0, 48);
    start_req(1'b0, 16'h7777);
    wait_done(100, ok, lat, res, bsy);
    ra = rom_addr;
    e = sb.pop_front();
    req0 = 1'b0;
    tests_run++;
    if (!ok || res !== {~e.idx, e.idx, e.fnd, e.addr} || lat != e.lat) begin
      failures++;
      $display("FAIL full_miss: got res %b after %0d cycles, expected %b after %0d",
               res, lat, {~e.idx, e.idx, e.fnd, e.addr}, e.lat);
    end
    tests_run++;
    if (ra !== 4'd15) begin
      failures++;
      $display("FAIL full_miss_no_wrap: got rom_addr %0d, expected 15", ra);
    end
    @(posedge clk); #1;
    load_rom_a();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_cache();
    logic        idx_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] key_t [3] = '{16'h3333, 16'h5555, 16'h3333};
    logic        fnd_t [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0]  adr_t [3] = '{4'd2, 4'd0, 4'd2};
`ifdef LAST_HIT_CACHE_EN
    int          lat_t [3] = '{9, 15, 1};
    logic [3:0]  ra_t  [3] = '{4'd2, 4'd4, 4'd4};
`else
    int          lat_t [3] = '{9, 15, 9};
    logic [3:0]  ra_t  [3] = '{4'd2, 4'd4, 4'd2};
`endif
    for (int i = 0; i < 3; i++) begin
      exp_t e; bit ok; int lat; logic [6:0] res; logic bsy; logic [3:0] ra;
      push_exp(idx_t[i], fnd_t[i], adr_t[i], lat_t[i]);
      start_req(idx_t[i], key_t[i]);
      wait_done(100, ok, lat, res, bsy);
      ra = rom_addr;
      e = sb.pop_front();
      if (e.idx) req1 = 1'b0; else req0 = 1'b0;
      tests_run++;
      if (!ok || res !== {~e.idx, e.idx, e.fnd, e.addr} || lat != e.lat) begin
        failures++;
        $display("FAIL cache%0d_result: got res %b after %0d cycles, expected %b after %0d",
                 i, res, lat, {~e.idx, e.idx, e.fnd, e.addr}, e.lat);
      end
      tests_run++;
      if (ra !== ra_t[i]) begin
        failures++;
        $display("FAIL cache%0d_romaddr: got %0d, expected %0d", i, ra, ra_t[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    bit          s0_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit          s1_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] k0_t  [5] = '{16'h1111, 16'h0000, 16'h3333, 16'h1111, 16'h0000};
    logic [15:0] k1_t  [5] = '{16'h2222, 16'h0000, 16'h0000, 16'h2222, 16'h0000};
    logic        idx_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  adr_t [5] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0};
    int          lat_t [5] = '{3, 7, 9, 6, 4};
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_t e; bit ok; int lat; logic [6:0] res; logic bsy;
      if (s0_t[i] || s1_t[i]) begin
        push_exp(idx_t[i], 1'b1, adr_t[i], lat_t[i]);
        if (s0_t[i] && s1_t[i]) push_exp(idx_t[i+1], 1'b1, adr_t[i+1], lat_t[i+1]);
        @(negedge clk);
        if (s0_t[i]) begin req0 = 1'b1; key0 = k0_t[i]; end
        if (s1_t[i]) begin req1 = 1'b1; key1 = k1_t[i]; end
        @(posedge clk);
      end
      wait_done(100, ok, lat, res, bsy);
      e = sb.pop_front();
      if (e.idx) req1 = 1'b0; else req0 = 1'b0;
      tests_run++;
      if (!ok || res !== {~e.idx, e.idx, e.fnd, e.addr} || lat != e.lat) begin
        failures++;
        $display("FAIL arb%0d_order: got res %b after %0d cycles, expected %b after %0d",
                 i, res, lat, {~e.idx, e.idx, e.fnd, e.addr}, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    start_req(1'b1, 16'hABCD);
    repeat (5) begin
      @(posedge clk); #1;
      if (done0 || done1) seen++;
    end
    tests_run++;
    if (busy !== 1'b1 || grant !== 1'b1 || rom_addr !== 4'd1) begin
      failures++;
      $display("FAIL midscan_progress: got busy/grant/rom_addr %b/%b/%0d, expected 1/1/1",
               busy, grant, rom_addr);
    end
    @(negedge clk); rst = 1'b1; req1 = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({done0, done1, found, match_addr, grant, busy, rom_addr} !== 13'd0) begin
      failures++;
      $display("FAIL midscan_reset_state: got %b, expected all zero",
               {done0, done1, found, match_addr, grant, busy, rom_addr});
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midscan_no_done: got %0d cycles with done/busy, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_hit_and_miss();
    test_full_miss();
    test_cache();
    test_arbitration();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
